mem_port_arbiter: RTL

- Shares the single memory port between two requesters: instruction fetch (IF, read-only) and the MEM-stage data access (D, read/write).
- Sequences each access through a fixed issue/wait/respond handshake.
- Data has priority, with a starvation guard that protects fetch.
- Sits between if_stage/MEM stage and the RAM helper; the hazard unit stalls the pipeline while a requester's done is outstanding.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch (IF) and data access (D)
//
// Each access runs through a fixed IDLE -> ISSUE -> WAIT -> RESP sequence.
// Data wins arbitration, but after STARVE_MAX consecutive data grants that
// kept a waiting fetch out, the fetch is granted.
//
// Optional build macro: MEM_PORT_ARB_PERF_EN adds the perf_* counter ports.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   if_req/if_addr      fetch request and byte address (held until if_done/if_kill)
//   if_kill             abandon the in-flight fetch; masks if_req while IDLE
//   if_done/if_rdata    fetch completion pulse and fetched doubleword
//   d_req/d_wen/d_addr  data request, write flag and byte address (held until d_done)
//   d_wdata/d_wmask     lane-aligned write data and bit mask
//   d_done/d_rdata      data completion pulse and read doubleword (reads only)
//   mem_en/mem_wen      RAM read / write enable (ISSUE only)
//   mem_idx             RAM doubleword index = (addr - BASE_ADDR) >> 3
//   mem_wdata/mem_wmask RAM write data and mask
//   mem_rdata           RAM read data, valid the cycle after mem_en
//   perf_*              grant and conflict counters (MEM_PORT_ARB_PERF_EN only)
module mem_port_arbiter #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_kill,
    output logic        if_done,
    output logic [63:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [63:0] d_wmask,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic        mem_en,
    output logic [63:0] mem_idx,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_wmask,
    input  logic [63:0] mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [63:0] perf_if_grants,
    output logic [63:0] perf_d_grants,
    output logic [63:0] perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    state_t      state;
    state_t      state_nxt;
    logic        own_if;
    logic        own_d;
    logic        cmd_wen;
    logic        killed;
    logic [3:0]  starve_cnt;

    logic        if_eff;
    logic        grant_if;
    logic        grant_d;
    logic        wen_sel;
    logic [63:0] addr_sel;

    // A killed fetch cannot compete in the same arbitration.
    assign if_eff   = if_req & ~if_kill;
    assign wen_sel  = grant_d & d_wen;
    assign addr_sel = grant_if ? if_addr : d_addr;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (if_eff && d_req) begin
                if (starve_cnt < STARVE_LIM) begin
                    grant_d = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else if (if_eff) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || grant_d) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The kill is also honoured combinationally so a kill raised during RESP
    // itself still suppresses the pulse.
    assign if_done = (state == RESP) & own_if & ~killed & ~if_kill;
    assign d_done  = (state == RESP) & own_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            own_if     <= 1'b0;
            own_d      <= 1'b0;
            cmd_wen    <= 1'b0;
            killed     <= 1'b0;
            starve_cnt <= 4'd0;
            if_rdata   <= 64'd0;
            d_rdata    <= 64'd0;
            mem_en     <= 1'b0;
            mem_wen    <= 1'b0;
            mem_idx    <= 64'd0;
            mem_wdata  <= 64'd0;
            mem_wmask  <= 64'd0;
        end else begin
            state <= state_nxt;

            // mem_* are loaded on the grant edge so they are live exactly
            // during ISSUE, and cleared on every other edge.
            if (grant_if || grant_d) begin
                own_if    <= grant_if;
                own_d     <= grant_d;
                cmd_wen   <= wen_sel;
                killed    <= 1'b0;
                mem_en    <= ~wen_sel;
                mem_wen   <= wen_sel;
                mem_idx   <= (addr_sel - BASE_ADDR) >> 3;
                mem_wdata <= wen_sel ? d_wdata : 64'd0;
                mem_wmask <= wen_sel ? d_wmask : 64'd0;
            end else begin
                mem_en    <= 1'b0;
                mem_wen   <= 1'b0;
                mem_idx   <= 64'd0;
                mem_wdata <= 64'd0;
                mem_wmask <= 64'd0;
            end

            if (grant_if) begin
                starve_cnt <= 4'd0;
            end else if (grant_d) begin
                starve_cnt <= if_eff ? starve_cnt + 4'd1 : 4'd0;
            end

            if (state != IDLE && own_if && if_kill) begin
                killed <= 1'b1;
            end

            if (state == WAIT && !cmd_wen) begin
                if (own_if) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end

            if (state == RESP) begin
                own_if <= 1'b0;
                own_d  <= 1'b0;
            end
        end
    end

`ifdef MEM_PORT_ARB_PERF_EN
    logic conflict;

    assign conflict = (state == IDLE) ? (if_req & d_req)
                                      : ((own_if & d_req) | (own_d & if_req));

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_if_grants       <= 64'd0;
            perf_d_grants        <= 64'd0;
            perf_conflict_cycles <= 64'd0;
        end else begin
            if (grant_if) perf_if_grants <= perf_if_grants + 64'd1;
            if (grant_d)  perf_d_grants  <= perf_d_grants + 64'd1;
            if (conflict) perf_conflict_cycles <= perf_conflict_cycles + 64'd1;
        end
    end
`endif

endmodule
